// File: rtl/crtc_fetch_sched.sv
// Arbitrates the shared video-memory port between the CRTC scanline fetcher and a host.
// Each HSYNC rise inside the fetch window pulls WORDS words into the line buffer; the host gets leftover slots.
module crtc_fetch_sched #(
    parameter int AW    = 16,
    parameter int DW    = 16,
    parameter int WORDS = 40,
    parameter int LBW   = 6
) (
    input  logic           dotclk_i,
    input  logic           reset_i,
    input  logic           hsync_i,
    input  logic           vsync_i,
    input  logic           vfen_i,
    input  logic [AW-1:0]  fbase_i,
    input  logic [AW-1:0]  stride_i,
    input  logic           clr_underrun_i,
    input  logic           hstb_i,
    input  logic           hwe_i,
    input  logic [AW-1:0]  hadr_i,
    input  logic [DW-1:0]  hdat_i,
    output logic           hack_o,
    output logic [DW-1:0]  hdat_o,
    output logic           mstb_o,
    output logic           mwe_o,
    output logic [AW-1:0]  madr_o,
    output logic [DW-1:0]  mdat_o,
    input  logic           mack_i,
    input  logic [DW-1:0]  mdat_i,
    output logic           lbwe_o,
    output logic [LBW-1:0] lbadr_o,
    output logic [DW-1:0]  lbdat_o,
    output logic           underrun_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        VID  = 2'd1,
        HOST = 2'd2
    } state_t;

    localparam logic [LBW-1:0] LAST = LBW'(WORDS - 1);

    state_t         state_q;
    logic           hs_q, vs_q;
    logic [AW-1:0]  lptr_q, lptr_d;
    logic [AW-1:0]  vaddr_q;
    logic [LBW-1:0] vcnt_q;
    logic           vpend_q;
    logic           underrun_q, underrun_d;
    logic           mstb_q, mwe_q, lbwe_q;
    logic [AW-1:0]  madr_q;
    logic [DW-1:0]  mdat_q, lbdat_q;
    logic [LBW-1:0] lbadr_q;

    logic           hs_rise, vs_rise, fetch_go;
    logic [AW-1:0]  line_base;

    always_comb begin
        hs_rise   = hsync_i & ~hs_q;
        vs_rise   = vsync_i & ~vs_q;
        fetch_go  = hs_rise & vfen_i;
        // A frame start on the same edge as the line start must feed the new base straight through.
        line_base = vs_rise ? fbase_i : lptr_q;
        lptr_d    = lptr_q;
        if (vs_rise)
            lptr_d = fbase_i;
        if (fetch_go)
            lptr_d = line_base + stride_i;
        underrun_d = underrun_q;
        if (hs_rise && (vpend_q || state_q == VID))
            underrun_d = 1'b1;
        else if (clr_underrun_i)
            underrun_d = 1'b0;
    end

    always_ff @(posedge dotclk_i) begin
        if (!reset_i) begin
            state_q    <= IDLE;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            lptr_q     <= '0;
            vaddr_q    <= '0;
            vcnt_q     <= '0;
            vpend_q    <= 1'b0;
            underrun_q <= 1'b0;
            mstb_q     <= 1'b0;
            mwe_q      <= 1'b0;
            madr_q     <= '0;
            mdat_q     <= '0;
            lbwe_q     <= 1'b0;
            lbadr_q    <= '0;
            lbdat_q    <= '0;
        end else begin
            hs_q       <= hsync_i;
            vs_q       <= vsync_i;
            lptr_q     <= lptr_d;
            underrun_q <= underrun_d;
            lbwe_q     <= 1'b0;

            // A new line always restarts the fetch; an unfinished one is simply dropped.
            if (hs_rise) begin
                if (vfen_i) begin
                    vaddr_q <= line_base;
                    vcnt_q  <= '0;
                    vpend_q <= 1'b1;
                end else begin
                    vpend_q <= 1'b0;
                end
            end

            case (state_q)
                IDLE: begin
                    if (fetch_go) begin
                        state_q <= VID;
                        mstb_q  <= 1'b1;
                        mwe_q   <= 1'b0;
                        madr_q  <= line_base;
                    end else if (vpend_q && !hs_rise) begin
                        state_q <= VID;
                        mstb_q  <= 1'b1;
                        mwe_q   <= 1'b0;
                        madr_q  <= vaddr_q;
                    end else if (hstb_i) begin
                        state_q <= HOST;
                        mstb_q  <= 1'b1;
                        mwe_q   <= hwe_i;
                        madr_q  <= hadr_i;
                        mdat_q  <= hdat_i;
                    end
                end
                VID: begin
                    if (hs_rise) begin
                        if (vfen_i) begin
                            madr_q <= line_base;
                        end else begin
                            state_q <= IDLE;
                            mstb_q  <= 1'b0;
                        end
                    end else if (mack_i) begin
                        lbwe_q  <= 1'b1;
                        lbadr_q <= vcnt_q;
                        lbdat_q <= mdat_i;
                        vcnt_q  <= vcnt_q + 1'b1;
                        vaddr_q <= vaddr_q + AW'(1);
                        madr_q  <= vaddr_q + AW'(1);
                        if (vcnt_q == LAST) begin
                            state_q <= IDLE;
                            mstb_q  <= 1'b0;
                            vpend_q <= 1'b0;
                        end
                    end
                end
                HOST: begin
                    if (mack_i) begin
                        state_q <= IDLE;
                        mstb_q  <= 1'b0;
                        mwe_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    mstb_q  <= 1'b0;
                end
            endcase
        end
    end

    assign hack_o     = mack_i & (state_q == HOST);
    assign hdat_o     = mdat_i;
    assign mstb_o     = mstb_q;
    assign mwe_o      = mwe_q;
    assign madr_o     = madr_q;
    assign mdat_o     = mdat_q;
    assign lbwe_o     = lbwe_q;
    assign lbadr_o    = lbadr_q;
    assign lbdat_o    = lbdat_q;
    assign underrun_o = underrun_q;

endmodule

// File: tb/tb_crtc_fetch_sched.sv
// Scoreboard bench for crtc_fetch_sched: expected video/host/line-buffer traffic is queued at stimulus time
// and retired by a negedge monitor as the DUT produces it.
module tb_crtc_fetch_sched;
    localparam int AW = 16, DW = 16, WORDS = 4, LBW = 3;

    logic           dotclk_i = 1'b0;
    logic           reset_i = 1'b0;
    logic           hsync_i = 1'b0, vsync_i = 1'b0, vfen_i = 1'b0;
    logic [AW-1:0]  fbase_i = '0, stride_i = '0;
    logic           clr_underrun_i = 1'b0;
    logic           hstb_i = 1'b0, hwe_i = 1'b0;
    logic [AW-1:0]  hadr_i = '0;
    logic [DW-1:0]  hdat_i = '0;
    logic           hack_o;
    logic [DW-1:0]  hdat_o;
    logic           mstb_o, mwe_o;
    logic [AW-1:0]  madr_o;
    logic [DW-1:0]  mdat_o;
    logic           mack_i = 1'b0;
    logic [DW-1:0]  mdat_i;
    logic           lbwe_o;
    logic [LBW-1:0] lbadr_o;
    logic [DW-1:0]  lbdat_o;
    logic           underrun_o;

    logic           use_fixed = 1'b0;
    logic [DW-1:0]  fixed_dat = '0;

    always #5 dotclk_i = ~dotclk_i;

    // Memory model: read data is a known scramble of the address unless a fixed word is forced.
    assign mdat_i = use_fixed ? fixed_dat : (madr_o ^ 16'hA5A5);

    crtc_fetch_sched #(.AW(AW), .DW(DW), .WORDS(WORDS), .LBW(LBW)) dut (
        .dotclk_i(dotclk_i), .reset_i(reset_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
        .vfen_i(vfen_i), .fbase_i(fbase_i), .stride_i(stride_i), .clr_underrun_i(clr_underrun_i),
        .hstb_i(hstb_i), .hwe_i(hwe_i), .hadr_i(hadr_i), .hdat_i(hdat_i),
        .hack_o(hack_o), .hdat_o(hdat_o), .mstb_o(mstb_o), .mwe_o(mwe_o),
        .madr_o(madr_o), .mdat_o(mdat_o), .mack_i(mack_i), .mdat_i(mdat_i),
        .lbwe_o(lbwe_o), .lbadr_o(lbadr_o), .lbdat_o(lbdat_o), .underrun_o(underrun_o)
    );

    typedef struct packed {
        logic [AW-1:0] adr;
        logic          we;
        logic [DW-1:0] wdat;
        logic [DW-1:0] rdat;
    } host_exp_t;

    logic [AW-1:0]     exp_vid[$];
    logic [LBW+DW-1:0] exp_lb[$];
    host_exp_t         exp_host[$];

    int vectors = 0, errors = 0;
    int cyc = 0, hack_cnt = 0, vid_acks = 0;
    int last_vid_cyc = 0, last_hack_cyc = 0, vid_at_hack = 0;
    logic [AW-1:0] lptr_m = '0;

    always @(negedge dotclk_i) begin : monitor
        logic [AW-1:0]     ea;
        logic [LBW+DW-1:0] el;
        host_exp_t         eh;
        cyc++;
        if (mstb_o && mack_i && !hack_o) begin
            vid_acks++;
            last_vid_cyc = cyc;
            vectors++;
            if (exp_vid.size() == 0) begin
                errors++;
                $display("FAIL vid_ack unexpected: madr=%h required none", madr_o);
            end else begin
                ea = exp_vid.pop_front();
                if (madr_o !== ea || mwe_o !== 1'b0) begin
                    errors++;
                    $display("FAIL vid_ack: madr=%h mwe=%b required madr=%h mwe=0", madr_o, mwe_o, ea);
                end
            end
        end
        if (hack_o) begin
            hack_cnt++;
            last_hack_cyc = cyc;
            vid_at_hack = vid_acks;
            vectors++;
            if (exp_host.size() == 0) begin
                errors++;
                $display("FAIL host_ack unexpected: madr=%h required none", madr_o);
            end else begin
                eh = exp_host.pop_front();
                if (madr_o !== eh.adr || mwe_o !== eh.we || hdat_o !== eh.rdat ||
                    (eh.we && mdat_o !== eh.wdat)) begin
                    errors++;
                    $display("FAIL host_ack: adr=%h we=%b wdat=%h rdat=%h required adr=%h we=%b wdat=%h rdat=%h",
                             madr_o, mwe_o, mdat_o, hdat_o, eh.adr, eh.we, eh.wdat, eh.rdat);
                end
            end
        end
        if (lbwe_o) begin
            vectors++;
            if (exp_lb.size() == 0) begin
                errors++;
                $display("FAIL lb_write unexpected: adr=%0d dat=%h required none", lbadr_o, lbdat_o);
            end else begin
                el = exp_lb.pop_front();
                if ({lbadr_o, lbdat_o} !== el) begin
                    errors++;
                    $display("FAIL lb_write: adr=%0d dat=%h required adr=%0d dat=%h",
                             lbadr_o, lbdat_o, el[LBW+DW-1:DW], el[DW-1:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge dotclk_i);
        #2;
    endtask

    task automatic push_line(input logic [AW-1:0] base);
        logic [AW-1:0] a;
        for (int i = 0; i < WORDS; i++) begin
            a = base + AW'(i);
            exp_vid.push_back(a);
            exp_lb.push_back({LBW'(i), a ^ 16'hA5A5});
        end
    endtask

    task automatic wait_drain(input int budget, input bit host_only, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (exp_host.size() == 0 &&
                (host_only || (exp_vid.size() == 0 && exp_lb.size() == 0))) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b0;
        step();
        step();
        vectors++;
        if ({mstb_o, hack_o, lbwe_o, underrun_o} !== 4'b0) begin
            errors++;
            $display("FAIL reset_outputs: mstb/hack/lbwe/underrun=%b required 0000",
                     {mstb_o, hack_o, lbwe_o, underrun_o});
        end
        vectors++;
        if (madr_o !== '0) begin
            errors++;
            $display("FAIL reset_madr: %h required 0000", madr_o);
        end
        reset_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if ({mstb_o, hack_o, lbwe_o, underrun_o} !== 4'b0) begin
                errors++;
                $display("FAIL idle_outputs: mstb/hack/lbwe/underrun=%b required 0000",
                         {mstb_o, hack_o, lbwe_o, underrun_o});
            end
        end
    endtask

    task automatic test_line_fetch();
        bit ok;
        fbase_i = 16'h1000;
        stride_i = 16'h0020;
        vfen_i = 1'b1;
        mack_i = 1'b1;
        vsync_i = 1'b1;
        step();
        vsync_i = 1'b0;
        lptr_m = fbase_i;
        for (int ln = 0; ln < 2; ln++) begin
            push_line(lptr_m);
            lptr_m = lptr_m + stride_i;
            hsync_i = 1'b1;
            step();
            hsync_i = 1'b0;
            wait_drain(30, 1'b0, ok);
            vectors++;
            if (!ok) begin
                errors++;
                $display("FAIL line_fetch_timeout: line %0d pending=%0d required 0", ln, exp_vid.size());
            end
            vectors++;
            if (mstb_o !== 1'b0) begin
                errors++;
                $display("FAIL line_fetch_mstb_drop: mstb=%b required 0", mstb_o);
            end
        end
    endtask

    task automatic test_host_read();
        bit ok;
        int h0;
        use_fixed = 1'b1;
        fixed_dat = 16'hBEEF;
        mack_i = 1'b0;
        hstb_i = 1'b1;
        hwe_i = 1'b0;
        hadr_i = 16'h0042;
        exp_host.push_back('{adr: 16'h0042, we: 1'b0, wdat: 16'h0000, rdat: 16'hBEEF});
        h0 = hack_cnt;
        repeat (3) step();
        vectors++;
        if (mstb_o !== 1'b1 || madr_o !== 16'h0042 || hack_o !== 1'b0) begin
            errors++;
            $display("FAIL host_stall: mstb=%b madr=%h hack=%b required 1 0042 0", mstb_o, madr_o, hack_o);
        end
        mack_i = 1'b1;
        wait_drain(10, 1'b1, ok);
        hstb_i = 1'b0;
        mack_i = 1'b0;
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL host_read_timeout: pending=%0d required 0", exp_host.size());
        end
        step();
        vectors++;
        if (hack_cnt - h0 != 1 || mstb_o !== 1'b0) begin
            errors++;
            $display("FAIL host_read_once: hack cycles=%0d mstb=%b required 1 0", hack_cnt - h0, mstb_o);
        end
        use_fixed = 1'b0;
    endtask

    task automatic test_priority_simul();
        bit ok;
        int v0;
        mack_i = 1'b1;
        hstb_i = 1'b1;
        hwe_i = 1'b1;
        hadr_i = 16'h0100;
        hdat_i = 16'h1234;
        exp_host.push_back('{adr: 16'h0100, we: 1'b1, wdat: 16'h1234, rdat: 16'h0100 ^ 16'hA5A5});
        push_line(lptr_m);
        lptr_m = lptr_m + stride_i;
        v0 = vid_acks;
        hsync_i = 1'b1;
        step();
        hsync_i = 1'b0;
        wait_drain(30, 1'b0, ok);
        hstb_i = 1'b0;
        hwe_i = 1'b0;
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL prio_simul_timeout: vid=%0d host=%0d required 0 0", exp_vid.size(), exp_host.size());
        end
        vectors++;
        if (vid_at_hack - v0 != WORDS || last_hack_cyc - last_vid_cyc != 2) begin
            errors++;
            $display("FAIL prio_simul_order: vid before hack=%0d gap=%0d required %0d 2",
                     vid_at_hack - v0, last_hack_cyc - last_vid_cyc, WORDS);
        end
    endtask

    task automatic test_priority_host_first();
        bit ok;
        int v0;
        mack_i = 1'b0;
        hstb_i = 1'b1;
        hwe_i = 1'b0;
        hadr_i = 16'h0200;
        exp_host.push_back('{adr: 16'h0200, we: 1'b0, wdat: 16'h0000, rdat: 16'h0200 ^ 16'hA5A5});
        v0 = vid_acks;
        step();
        push_line(lptr_m);
        lptr_m = lptr_m + stride_i;
        hsync_i = 1'b1;
        step();
        hsync_i = 1'b0;
        mack_i = 1'b1;
        wait_drain(10, 1'b1, ok);
        hstb_i = 1'b0;
        vectors++;
        if (!ok || vid_at_hack != v0) begin
            errors++;
            $display("FAIL host_first_order: done=%b vid before hack=%0d required 1 0", ok, vid_at_hack - v0);
        end
        wait_drain(30, 1'b0, ok);
        vectors++;
        if (!ok || last_vid_cyc - last_hack_cyc != WORDS + 1) begin
            errors++;
            $display("FAIL host_first_fetch: done=%b last vid gap=%0d required 1 %0d",
                     ok, last_vid_cyc - last_hack_cyc, WORDS + 1);
        end
    endtask

    task automatic test_underrun();
        bit ok;
        logic [AW-1:0] addr_a, addr_b;
        mack_i = 1'b0;
        addr_a = lptr_m;
        lptr_m = lptr_m + stride_i;
        hsync_i = 1'b1;
        step();
        hsync_i = 1'b0;
        repeat (3) step();
        vectors++;
        if (mstb_o !== 1'b1 || madr_o !== addr_a || underrun_o !== 1'b0) begin
            errors++;
            $display("FAIL underrun_stall: mstb=%b madr=%h underrun=%b required 1 %h 0",
                     mstb_o, madr_o, underrun_o, addr_a);
        end
        addr_b = lptr_m;
        lptr_m = lptr_m + stride_i;
        hsync_i = 1'b1;
        step();
        hsync_i = 1'b0;
        vectors++;
        if (underrun_o !== 1'b1 || madr_o !== addr_b) begin
            errors++;
            $display("FAIL underrun_set: underrun=%b madr=%h required 1 %h", underrun_o, madr_o, addr_b);
        end
        push_line(addr_b);
        mack_i = 1'b1;
        wait_drain(30, 1'b0, ok);
        vectors++;
        if (!ok || underrun_o !== 1'b1) begin
            errors++;
            $display("FAIL underrun_restart: done=%b underrun=%b required 1 1", ok, underrun_o);
        end
        clr_underrun_i = 1'b1;
        step();
        clr_underrun_i = 1'b0;
        vectors++;
        if (underrun_o !== 1'b0) begin
            errors++;
            $display("FAIL underrun_clear: underrun=%b required 0", underrun_o);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        bit saw;
        fbase_i = 16'hFFFE;
        mack_i = 1'b1;
        push_line(16'hFFFE);
        lptr_m = 16'hFFFE + stride_i;
        vsync_i = 1'b1;
        hsync_i = 1'b1;
        step();
        vsync_i = 1'b0;
        hsync_i = 1'b0;
        wait_drain(30, 1'b0, ok);
        vectors++;
        if (!ok || mstb_o !== 1'b0) begin
            errors++;
            $display("FAIL wrap_fetch: done=%b mstb=%b required 1 0", ok, mstb_o);
        end
        push_line(lptr_m);
        lptr_m = lptr_m + stride_i;
        hsync_i = 1'b1;
        step();
        hsync_i = 1'b0;
        wait_drain(30, 1'b0, ok);
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL wrap_next_line: pending=%0d required 0", exp_vid.size());
        end
        vfen_i = 1'b0;
        hsync_i = 1'b1;
        step();
        hsync_i = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            saw = saw | mstb_o;
        end
        vectors++;
        if (saw !== 1'b0) begin
            errors++;
            $display("FAIL no_fetch_outside_vfen: mstb seen=%b required 0", saw);
        end
    endtask

    initial begin
        test_reset();
        test_line_fetch();
        test_host_read();
        test_priority_simul();
        test_priority_host_first();
        test_underrun();
        test_wrap();
        step();
        vectors++;
        if (exp_vid.size() != 0 || exp_lb.size() != 0 || exp_host.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: vid=%0d lb=%0d host=%0d required 0 0 0",
                     exp_vid.size(), exp_lb.size(), exp_host.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
